// File: rtl/run_controller.sv
// Core run/step controller: turns synchronised run/step/halt requests into a divided one-cycle
// core_tick enable, with N-step bursts, PC breakpoints and a forced halt.
module run_controller #(
  parameter int DIV_WIDTH   = 16,
  parameter int STEP_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_BP      = 2,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_WIDTH  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run_en,
  input  logic                         step_req,
  input  logic                         halt_req,
  input  logic [STEP_WIDTH-1:0]        step_count,
  input  logic [DIV_WIDTH-1:0]         div_value,
  input  logic [ADDR_WIDTH-1:0]        pc,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]            bp_en,
  output logic                         core_tick,
  output logic                         running,
  output logic                         halted_bp,
  output logic [IDX_WIDTH-1:0]         bp_hit_idx,
  output logic [STEP_WIDTH-1:0]        steps_left
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t state, state_d;

  // Bit order in each stage: {halt, step, run}.
  logic [2:0] sync_q [SYNC_STAGES];
  logic       step_prev;
  logic       run_s, step_s, halt_s, step_edge;

  logic [DIV_WIDTH-1:0]  div_cnt;
  logic                  skip;
  logic                  decision;
  logic                  bp_match;
  logic [IDX_WIDTH-1:0]  bp_idx;
  logic [STEP_WIDTH-1:0] steps_load;

  logic tick_d, div_clr, div_inc, load_steps, dec_steps, clr_steps;
  logic set_skip, clr_skip, latch_idx;

  // Synchroniser flops reset to 0 so a request held through reset looks like a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      step_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q[0] <= {halt_req, step_req, run_en};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      step_prev <= sync_q[SYNC_STAGES-1][1];
    end
  end

  assign run_s     = sync_q[SYNC_STAGES-1][0];
  assign step_s    = sync_q[SYNC_STAGES-1][1];
  assign halt_s    = sync_q[SYNC_STAGES-1][2];
  assign step_edge = step_s & ~step_prev;

  // >= rather than == so shrinking div_value mid-count cannot make the counter wrap.
  assign decision   = (div_cnt >= div_value);
  assign steps_load = (step_count == '0) ? STEP_WIDTH'(1) : step_count;

  // Scan high-to-low so the lowest matching comparator wins.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        bp_match = 1'b1;
        bp_idx   = IDX_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d    = state;
    tick_d     = 1'b0;
    div_clr    = 1'b0;
    div_inc    = 1'b0;
    load_steps = 1'b0;
    dec_steps  = 1'b0;
    clr_steps  = 1'b0;
    set_skip   = 1'b0;
    clr_skip   = 1'b0;
    latch_idx  = 1'b0;
    if (halt_s) begin
      state_d   = ST_IDLE;
      clr_steps = 1'b1;
      div_clr   = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run_s) begin
            state_d = ST_RUN;
            div_clr = 1'b1;
          end else if (step_edge) begin
            state_d    = ST_STEP;
            div_clr    = 1'b1;
            load_steps = 1'b1;
          end
        end
        ST_RUN: begin
          if (!run_s) begin
            state_d = ST_IDLE;
          end else if (decision) begin
            div_clr = 1'b1;
            if (bp_match && !skip) begin
              state_d   = ST_BREAK;
              latch_idx = 1'b1;
            end else begin
              tick_d   = 1'b1;
              clr_skip = 1'b1;
            end
          end else begin
            div_inc = 1'b1;
          end
        end
        ST_STEP: begin
          if (decision) begin
            div_clr = 1'b1;
            if (bp_match && !skip) begin
              state_d   = ST_BREAK;
              latch_idx = 1'b1;
            end else begin
              tick_d    = 1'b1;
              clr_skip  = 1'b1;
              dec_steps = (steps_left != '0);
              if (steps_left <= STEP_WIDTH'(1)) state_d = ST_IDLE;
            end
          end else begin
            div_inc = 1'b1;
          end
        end
        ST_BREAK: begin
          if (!run_s) begin
            state_d = ST_IDLE;
          end else if (step_edge) begin
            // Skip lets the first tick leave the PC that caused the break.
            state_d    = ST_STEP;
            div_clr    = 1'b1;
            load_steps = 1'b1;
            set_skip   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running   = (state == ST_RUN) || (state == ST_STEP);
    halted_bp = (state == ST_BREAK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_tick  <= 1'b0;
      div_cnt    <= '0;
      steps_left <= '0;
      skip       <= 1'b0;
      bp_hit_idx <= '0;
    end else begin
      core_tick <= tick_d;
      if (div_clr)      div_cnt <= '0;
      else if (div_inc) div_cnt <= div_cnt + DIV_WIDTH'(1);
      if (clr_steps)       steps_left <= '0;
      else if (load_steps) steps_left <= steps_load;
      else if (dec_steps)  steps_left <= steps_left - STEP_WIDTH'(1);
      if (set_skip)      skip <= 1'b1;
      else if (clr_skip) skip <= 1'b0;
      if (latch_idx) bp_hit_idx <= bp_idx;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller: reset, divided free-run, step bursts,
// breakpoint stop and step-off, forced halt, and run/step collision in IDLE.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        step_req = 1'b0;
  logic        halt_req = 1'b0;
  logic [7:0]  step_count = '0;
  logic [15:0] div_value = '0;
  logic [7:0]  pc = '0;
  logic [15:0] bp_addr = '0;
  logic [1:0]  bp_en = '0;
  logic        core_tick, running, halted_bp;
  logic [0:0]  bp_hit_idx;
  logic [7:0]  steps_left;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ticks = 0;
  logic [15:0] tick_vec;

  run_controller dut (
    .clk        (clk),
    .rst        (rst_n),
    .run_en     (run_en),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .step_count (step_count),
    .div_value  (div_value),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .core_tick  (core_tick),
    .running    (running),
    .halted_bp  (halted_bp),
    .bp_hit_idx (bp_hit_idx),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample on the falling edge and let the modelled core advance pc on each tick.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (core_tick) begin
        ticks++;
        pc = pc + 8'd1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(2);
    check("rst_tick", core_tick, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted_bp, 0);
    check("rst_idx", bp_hit_idx, 0);
    check("rst_steps", steps_left, 0);

    // Reset pulse in the middle of a div_value=0 free run
    rst_n  = 1'b1;
    run_en = 1'b1;
    cyc(3);
    check("t1_running", running, 1);
    check("t1_entry_notick", core_tick, 0);
    cyc(1);
    check("t1_tick", core_tick, 1);
    #1 rst_n = 1'b0;
    run_en = 1'b0;
    #1;
    check("t1_async_tick", core_tick, 0);
    check("t1_async_running", running, 0);
    check("t1_async_steps", steps_left, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    check("t1_idle_running", running, 0);
    check("t1_idle_tick", core_tick, 0);

    // div_value=3 free run: one tick every 4 cycles, first 4 cycles after entry
    div_value = 16'd3;
    ticks = 0;
    run_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      tick_vec[k] = core_tick;
      if (k == 2) check("t2_running", running, 1);
    end
    check("t2_pattern", tick_vec, 16'h4440);
    run_en = 1'b0;
    cyc(4);
    check("t2_stop_running", running, 0);
    check("t2_tick_total", ticks, 3);

    // 5-step burst at div_value=0
    div_value  = 16'd0;
    step_count = 8'd5;
    ticks = 0;
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(2);
    check("t3_running", running, 1);
    check("t3_steps_load", steps_left, 5);
    for (int k = 4; k >= 0; k--) begin
      cyc(1);
      check("t3_steps", steps_left, k);
      check("t3_tick", core_tick, 1);
    end
    check("t3_done_running", running, 0);
    cyc(1);
    check("t3_after_tick", core_tick, 0);
    check("t3_tick_total", ticks, 5);

    // Breakpoint 1 at 0x10 (breakpoint 0 at 0x0D disabled), then step off it
    pc = 8'h0C;
    bp_addr = {8'h10, 8'h0D};
    bp_en = 2'b10;
    ticks = 0;
    run_en = 1'b1;
    cyc(8);
    check("t4_halted", halted_bp, 1);
    check("t4_running", running, 0);
    check("t4_idx", bp_hit_idx, 1);
    check("t4_ticks", ticks, 4);
    check("t4_pc", pc, 8'h10);
    check("t4_tick", core_tick, 0);
    cyc(2);
    check("t4_hold_halted", halted_bp, 1);
    check("t4_hold_ticks", ticks, 4);
    step_count = 8'd1;
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    run_en = 1'b0;
    cyc(3);
    check("t4_step_tick", core_tick, 1);
    check("t4_step_pc", pc, 8'h11);
    check("t4_step_running", running, 0);
    check("t4_step_halted", halted_bp, 0);
    cyc(2);
    check("t4_end_running", running, 0);
    check("t4_end_ticks", ticks, 5);
    check("t4_idx_hold", bp_hit_idx, 1);

    // Forced halt in the middle of an 8-step burst
    step_count = 8'd8;
    ticks = 0;
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(5);
    halt_req = 1'b1;
    cyc(2);
    check("t5_steps_mid", steps_left, 3);
    check("t5_ticks_mid", ticks, 5);
    check("t5_running_mid", running, 1);
    cyc(1);
    check("t5_halt_tick", core_tick, 0);
    check("t5_halt_running", running, 0);
    check("t5_halt_steps", steps_left, 0);
    halt_req = 1'b0;
    cyc(4);
    check("t5_final_ticks", ticks, 5);
    check("t5_final_running", running, 0);

    // run_en and step edge together in IDLE: run wins, steps_left untouched
    step_count = 8'd3;
    run_en = 1'b1;
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(2);
    check("t6_running", running, 1);
    check("t6_steps", steps_left, 0);
    run_en = 1'b0;
    cyc(4);
    check("t6_idle", running, 0);

    // step_count=0 behaves as a single step
    step_count = 8'd0;
    ticks = 0;
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(2);
    check("t6_zero_running", running, 1);
    check("t6_zero_steps", steps_left, 1);
    cyc(1);
    check("t6_zero_tick", core_tick, 1);
    check("t6_zero_done", running, 0);
    check("t6_zero_steps_end", steps_left, 0);
    cyc(3);
    check("t6_zero_ticks", ticks, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
